// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Multi-cycle instruction-fetch controller. Owns the program counter, issues
//   one instruction-memory read at a time, captures the response and holds it
//   with its PC for decode. A redirect squashes any in-flight or held fetch and
//   restarts fetch at the (word-aligned) redirect target.
//
// Ports
//   clock            rising-edge clock
//   reset            synchronous reset, active-low (0 = reset)
//   mem_req_valid    fetch request valid (state REQ)
//   mem_req_ready    memory accepts request
//   mem_req_addr     fetch address (internal pc)
//   mem_rsp_valid    read data valid, one pulse per accepted request
//   mem_rsp_data     instruction word
//   insn_valid       instruction held for decode (state HOLD)
//   insn_ready       decode accepts instruction
//   insn_data        held instruction
//   insn_pc          address of held instruction
//   redirect_valid   squash and restart fetch at redirect_pc
//   redirect_pc      new fetch address
//   misalign         sticky: a redirect target had nonzero low bits
//   fetch_count      number of completed decode handshakes

module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0100_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        insn_valid,
  input  logic        insn_ready,
  output logic [31:0] insn_data,
  output logic [31:0] insn_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        misalign,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_drop;        // outstanding request is stale; discard its response
  logic        r_misalign;
  logic [31:0] r_fetch_count;
  logic [31:0] r_insn_data;
  logic [31:0] r_insn_pc;

  state_t      w_next_state;
  logic [31:0] w_next_pc;
  logic        w_next_drop;
  logic        w_next_misalign;
  logic [31:0] w_next_fetch_count;
  logic [31:0] w_next_insn_data;
  logic [31:0] w_next_insn_pc;
  logic [31:0] w_redirect_target;

  assign w_redirect_target = {redirect_pc[31:2], 2'b00};

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next_state       = r_state;
    w_next_pc          = r_pc;
    w_next_drop        = r_drop;
    w_next_misalign    = r_misalign;
    w_next_fetch_count = r_fetch_count;
    w_next_insn_data   = r_insn_data;
    w_next_insn_pc     = r_insn_pc;

    if (r_state != S_RST && redirect_valid) begin
      w_next_pc = w_redirect_target;
      if (redirect_pc[1:0] != 2'b00) w_next_misalign = 1'b1;
    end

    unique case (r_state)
      S_RST: w_next_state = S_REQ;

      S_REQ: begin
        if (mem_req_ready) begin
          // An accepted request that coincides with a redirect is already stale.
          w_next_state = S_WAIT;
          w_next_drop  = redirect_valid;
        end
      end

      S_WAIT: begin
        if (mem_rsp_valid) begin
          if (redirect_valid || r_drop) begin
            w_next_state = S_REQ;
            w_next_drop  = 1'b0;
          end else begin
            w_next_state     = S_HOLD;
            w_next_insn_data = mem_rsp_data;
            w_next_insn_pc   = r_pc;
            w_next_pc        = r_pc + 32'd4;
          end
        end else if (redirect_valid) begin
          w_next_drop = 1'b1;
        end
      end

      S_HOLD: begin
        // A redirect squashes the held instruction; a same-cycle insn_ready
        // is not a completed handshake.
        if (redirect_valid) begin
          w_next_state = S_REQ;
        end else if (insn_ready) begin
          w_next_state       = S_REQ;
          w_next_fetch_count = r_fetch_count + 32'd1;
        end
      end

      default: w_next_state = S_RST;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= S_RST;
      r_pc          <= RESET_PC;
      r_drop        <= 1'b0;
      r_misalign    <= 1'b0;
      r_fetch_count <= 32'd0;
      r_insn_data   <= 32'd0;
      r_insn_pc     <= 32'd0;
    end else begin
      r_state       <= w_next_state;
      r_pc          <= w_next_pc;
      r_drop        <= w_next_drop;
      r_misalign    <= w_next_misalign;
      r_fetch_count <= w_next_fetch_count;
      r_insn_data   <= w_next_insn_data;
      r_insn_pc     <= w_next_insn_pc;
    end
  end

  // Handshake outputs decode registered state only.
  assign mem_req_valid = (r_state == S_REQ);
  assign insn_valid    = (r_state == S_HOLD);
  assign mem_req_addr  = r_pc;
  assign insn_data     = r_insn_data;
  assign insn_pc       = r_insn_pc;
  assign misalign      = r_misalign;
  assign fetch_count   = r_fetch_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//   Directed bench for fetch_sequencer. Inputs change and outputs are sampled
//   on the falling edge; the design registers on the rising edge.

module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0100_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] insn_data;
  logic [31:0] insn_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_count = 32'd0;

  fetch_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clock          (clock),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .insn_valid     (insn_valid),
    .insn_ready     (insn_ready),
    .insn_data      (insn_data),
    .insn_pc        (insn_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign       (misalign),
    .fetch_count    (fetch_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Entered in REQ at exp_pc; leaves the design in HOLD with insn_ready=0.
  task automatic fetch_one(input logic [31:0] exp_pc, input logic [31:0] data);
    logic [31:0] next_pc;
    next_pc = exp_pc + 32'd4;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_pc) begin
      errors++;
      $display("FAIL fetch_req: valid=%b addr=%h, expected valid=1 addr=%h",
               mem_req_valid, mem_req_addr, exp_pc);
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    checks++;
    if (mem_req_valid !== 1'b0 || insn_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_wait: req_valid=%b insn_valid=%b, expected 0 0",
               mem_req_valid, insn_valid);
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = data;
    tick();
    mem_rsp_valid = 1'b0;
    checks++;
    if (insn_valid !== 1'b1 || insn_pc !== exp_pc || insn_data !== data ||
        mem_req_addr !== next_pc) begin
      errors++;
      $display("FAIL fetch_hold: valid=%b pc=%h data=%h addr=%h, expected 1 %h %h %h",
               insn_valid, insn_pc, insn_data, mem_req_addr, exp_pc, data, next_pc);
    end
  endtask

  task automatic release_insn();
    insn_ready = 1'b1;
    tick();
    insn_ready = 1'b0;
    exp_count = exp_count + 32'd1;
    checks++;
    if (fetch_count !== exp_count || insn_valid !== 1'b0 || mem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL release: count=%0d insn_valid=%b req_valid=%b, expected %0d 0 1",
               fetch_count, insn_valid, mem_req_valid, exp_count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0;
    insn_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    repeat (2) tick();
    checks++;
    if (mem_req_valid !== 1'b0 || insn_valid !== 1'b0 || mem_req_addr !== RESET_PC ||
        misalign !== 1'b0 || fetch_count !== 32'd0 || insn_data !== 32'd0 || insn_pc !== 32'd0) begin
      errors++;
      $display("FAIL reset_values: rv=%b iv=%b addr=%h mis=%b cnt=%0d d=%h pc=%h",
               mem_req_valid, insn_valid, mem_req_addr, misalign, fetch_count, insn_data, insn_pc);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== RESET_PC) begin
      errors++;
      $display("FAIL first_req: valid=%b addr=%h, expected 1 %h", mem_req_valid, mem_req_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 3; i++) begin
      fetch_one(RESET_PC + 32'(4 * i), 32'hA000_0000 + 32'(i));
      release_insn();
    end
  endtask

  task automatic test_hold_stall();
    fetch_one(32'h0100_000C, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      // A stray response outside WAIT must be ignored.
      mem_rsp_valid = (i == 2);
      mem_rsp_data  = 32'h1234_5678;
      tick();
      checks++;
      if (insn_valid !== 1'b1 || insn_data !== 32'hDEAD_BEEF || insn_pc !== 32'h0100_000C ||
          mem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold_stall[%0d]: iv=%b d=%h pc=%h rv=%b", i, insn_valid, insn_data, insn_pc, mem_req_valid);
      end
    end
    mem_rsp_valid = 1'b0;
    release_insn();
  endtask

  task automatic test_redirect_wait();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0100_0100;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (mem_req_valid !== 1'b0 || insn_valid !== 1'b0 || mem_req_addr !== 32'h0100_0100) begin
      errors++;
      $display("FAIL redir_wait: rv=%b iv=%b addr=%h", mem_req_valid, insn_valid, mem_req_addr);
    end
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hBAD0_BAD0;
    tick();
    mem_rsp_valid = 1'b0;
    checks++;
    if (insn_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0100_0100) begin
      errors++;
      $display("FAIL redir_wait_discard: iv=%b rv=%b addr=%h, expected 0 1 01000100",
               insn_valid, mem_req_valid, mem_req_addr);
    end
  endtask

  task automatic test_back_to_back();
    mem_req_ready  = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0100_0200;
    tick();
    mem_req_ready  = 1'b0;
    redirect_valid = 1'b0;
    checks++;
    if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0100_0200) begin
      errors++;
      $display("FAIL redir_accept: rv=%b addr=%h, expected 0 01000200", mem_req_valid, mem_req_addr);
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hBAD1_BAD1;
    tick();
    mem_rsp_valid = 1'b0;
    checks++;
    if (insn_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0100_0200) begin
      errors++;
      $display("FAIL redir_accept_discard: iv=%b rv=%b addr=%h", insn_valid, mem_req_valid, mem_req_addr);
    end
    fetch_one(32'h0100_0200, 32'h0000_0013);
    insn_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0100_0300;
    tick();
    insn_ready     = 1'b0;
    redirect_valid = 1'b0;
    checks++;
    if (fetch_count !== exp_count || insn_valid !== 1'b0 || mem_req_valid !== 1'b1 ||
        mem_req_addr !== 32'h0100_0300) begin
      errors++;
      $display("FAIL redir_hold: cnt=%0d iv=%b rv=%b addr=%h, expected %0d 0 1 01000300",
               fetch_count, insn_valid, mem_req_valid, mem_req_addr, exp_count);
    end
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0100_0013;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (misalign !== 1'b1 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0100_0010) begin
      errors++;
      $display("FAIL misalign_set: mis=%b rv=%b addr=%h, expected 1 1 01000010",
               misalign, mem_req_valid, mem_req_addr);
    end
    fetch_one(32'h0100_0010, 32'h5555_AAAA);
    release_insn();
    checks++;
    if (misalign !== 1'b1) begin
      errors++;
      $display("FAIL misalign_sticky: mis=%b, expected 1", misalign);
    end
  endtask

  task automatic test_wrap_and_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    fetch_one(32'hFFFF_FFFC, 32'hCAFE_F00D);
    release_insn();
    checks++;
    if (mem_req_addr !== 32'h0000_0000) begin
      errors++;
      $display("FAIL pc_wrap: addr=%h, expected 00000000", mem_req_addr);
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    // Reset overrides a same-cycle response and redirect.
    reset          = 1'b0;
    mem_rsp_valid  = 1'b1;
    mem_rsp_data   = 32'h7777_7777;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0200_0000;
    tick();
    mem_rsp_valid  = 1'b0;
    redirect_valid = 1'b0;
    checks++;
    if (mem_req_valid !== 1'b0 || insn_valid !== 1'b0 || mem_req_addr !== RESET_PC ||
        misalign !== 1'b0 || fetch_count !== 32'd0 || insn_data !== 32'd0 || insn_pc !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset: rv=%b iv=%b addr=%h mis=%b cnt=%0d d=%h pc=%h",
               mem_req_valid, insn_valid, mem_req_addr, misalign, fetch_count, insn_data, insn_pc);
    end
    reset = 1'b1;
    tick();
    exp_count = 32'd0;
    fetch_one(RESET_PC, 32'h0BAD_C0DE);
    release_insn();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_hold_stall();
    test_redirect_wait();
    test_back_to_back();
    test_misalign();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle instruction-fetch controller for the pd core. Owns the program counter, issues one instruction-memory read at a time over a valid/ready request channel, captures the response, and presents it with its PC to decode over a valid/ready channel. Redirects (branch/jump targets) from later stages squash in-flight and held fetches.

## Interface
- RESET_PC, 32'h01000000, PC loaded by reset.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-low (0 = reset).
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  32  fetch address, equal to the internal pc.
- mem_rsp_valid  in  1  read data valid, one pulse per accepted request.
- mem_rsp_data  in  32  instruction word.
- insn_valid  out  1  instruction held for decode.
- insn_ready  in  1  decode accepts instruction.
- insn_data  out  32  held instruction.
- insn_pc  out  32  address of held instruction.
- redirect_valid  in  1  squash and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address.
- misalign  out  1  sticky: a redirect had redirect_pc[1:0] != 0.
- fetch_count  out  32  count of completed decode handshakes.

## Operation
- States: RST, REQ, WAIT, HOLD. Single outstanding request; drop flag marks a stale one.
- mem_req_valid = (state==REQ); insn_valid = (state==HOLD); both decoded from registered state only.
- RST: entered while reset=0; next cycle after reset=1 -> REQ.
- REQ: mem_req_valid=1. On mem_req_ready -> WAIT, drop=0.
- WAIT: on mem_rsp_valid with drop=0: insn_data<=mem_rsp_data, insn_pc<=pc, pc<=pc+4, -> HOLD. With drop=1: discard, drop<=0, -> REQ.
- HOLD: on insn_ready -> REQ, fetch_count+=1.
- Redirect (highest priority, any non-RST state): pc<={redirect_pc[31:2],2'b00}; misalign<=1 if redirect_pc[1:0]!=0.
  - REQ without ready: stay REQ; address changes next cycle (memory tolerates address change while unaccepted).
  - REQ with ready same cycle: request counts as accepted; -> WAIT with drop=1.
  - WAIT without rsp: drop<=1, stay WAIT. WAIT with rsp same cycle: response discarded, -> REQ, drop<=0.
  - HOLD: held instruction squashed, -> REQ; a same-cycle insn_ready is ignored (no count increment); decode must qualify with redirect.
- mem_rsp_valid outside WAIT is ignored.
- pc arithmetic modulo 2^32: 32'hFFFFFFFC + 4 = 32'h00000000. fetch_count wraps likewise.

## Timing
- Reset values (reset=0 at an edge): state=RST, pc=RESET_PC, drop=0, misalign=0, fetch_count=0, insn_data=0, insn_pc=0; hence mem_req_valid=0, insn_valid=0, mem_req_addr=RESET_PC.
- Reset mid-operation overrides everything, including a pending redirect or response; an outstanding memory response returning after reset is ignored (arrives outside WAIT, or is discarded if a new request is already in WAIT — memory is reset by the same signal, so none returns).
- First request: mem_req_valid=1 in cycle 1 after reset deasserts.
- Memory responds at least 1 cycle after acceptance; a response in the acceptance cycle is not supported.
- Best-case throughput: 3 cycles per instruction (REQ accepted, WAIT response, HOLD consumed).
- insn_data/insn_pc stable while insn_valid=1 and insn_ready=0.
- Redirect-to-request: new address on mem_req_addr in the cycle after redirect_valid.

## Test plan
- Reset release, memory ready=1, 1-cycle response latency, insn_ready=1 -> requests at 0x01000000, 0x01000004, 0x01000008 every 3 cycles; insn_pc matches; fetch_count=3 after 9 cycles.
- insn_ready=0 for 5 cycles in HOLD -> insn_valid held, insn_data/insn_pc unchanged, no new mem_req_valid; fetch_count increments once on release.
- Redirect to 0x01000100 while in WAIT, response arrives 2 cycles later -> response discarded, no insn_valid, next request at 0x01000100.
- Redirect to 0x01000200 in same cycle as mem_req_ready -> WAIT with drop, stale response discarded, next request at 0x01000200; redirect in HOLD with insn_ready=1 -> fetch_count unchanged.
- Redirect to 0x01000013 -> misalign=1 sticky, next request at 0x01000010; misalign cleared only by reset.
- Redirect to 0xFFFFFFFC, one fetch -> insn_pc=0xFFFFFFFC, next request at 0x00000000; assert reset=0 mid-WAIT -> all outputs at reset values next cycle.
